// File: rtl/fc_seq_engine.sv
// rtl/fc_seq_engine.sv - runtime-configurable fully-connected layer sequencer
module fc_seq_engine #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int ADDR_W = 14,
  parameter int CNT_W  = 8,
  parameter int ACC_W  = 40
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_in,
  input  logic [CNT_W-1:0]  num_out,
  input  logic [ADDR_W-1:0] x_base,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] b_base,
  input  logic [ADDR_W-1:0] y_base,
  input  logic              relu_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  max_idx,
  output logic [DATA_W-1:0] max_val
);

  typedef enum logic [2:0] {IDLE, BIAS, XRD, WRD, DRAIN, WRITE, FIN} state_t;

  // Tag carried alongside each read so the returning word is routed by what
  // was asked for, two edges after the request was registered.
  typedef enum logic [1:0] {RD_NONE, RD_BIAS, RD_X, RD_W} rd_kind_t;

  localparam int PROD_W = 2 * DATA_W;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  state_t   state, state_nxt;
  rd_kind_t kind_q, kind_d, kind_nxt;

  // Layer configuration latched at the accepted start
  logic [CNT_W-1:0]  n_cfg, m_cfg;
  logic [ADDR_W-1:0] xb_cfg, bb_cfg, yb_cfg;
  logic              relu_cfg;

  // Loop counters and the running weight-row pointer (w_base + j*N)
  logic [CNT_W-1:0]  i_cnt, j_cnt;
  logic [CNT_W:0]    i_inc, j_inc;
  logic [ADDR_W-1:0] w_row;

  // Registered-output next values
  logic [ADDR_W-1:0] addr_nxt;
  logic              rd_nxt, wr_nxt, busy_nxt, done_nxt;

  // Arithmetic
  logic signed [DATA_W-1:0] x_q;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc, acc_nxt, acc_shr;
  logic [DATA_W-1:0]        result;

  assign i_inc = {1'b0, i_cnt} + (CNT_W+1)'(1);
  assign j_inc = {1'b0, j_cnt} + (CNT_W+1)'(1);
  assign prod  = x_q * $signed(mem_rd_data);

  // Accumulator update from the word returning this cycle; the WRITE edge
  // consumes the final product (or the bias when N=0) through this path.
  always_comb begin
    acc_nxt = acc;
    case (kind_d)
      RD_BIAS: acc_nxt = ACC_W'($signed(mem_rd_data)) <<< FRAC_W;
      RD_W:    acc_nxt = acc + ACC_W'(prod);
      default: acc_nxt = acc;
    endcase
  end

  // Rescale, saturate to the word range, then optional ReLU
  always_comb begin
    acc_shr = acc_nxt >>> FRAC_W;
    if (acc_shr > SAT_MAX) begin
      result = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (acc_shr < SAT_MIN) begin
      result = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      result = acc_shr[DATA_W-1:0];
    end
    if (relu_cfg && result[DATA_W-1]) begin
      result = '0;
    end
  end

  // Next-state and next registered-output decode
  always_comb begin
    state_nxt = state;
    addr_nxt  = mem_addr;
    rd_nxt    = 1'b0;
    wr_nxt    = 1'b0;
    kind_nxt  = RD_NONE;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          busy_nxt  = 1'b1;
          state_nxt = (num_out == '0) ? FIN : BIAS;
        end
      end
      BIAS: begin
        rd_nxt    = 1'b1;
        addr_nxt  = bb_cfg + ADDR_W'(j_cnt);
        kind_nxt  = RD_BIAS;
        state_nxt = (n_cfg == '0) ? DRAIN : XRD;
      end
      XRD: begin
        rd_nxt    = 1'b1;
        addr_nxt  = xb_cfg + ADDR_W'(i_cnt);
        kind_nxt  = RD_X;
        state_nxt = WRD;
      end
      WRD: begin
        rd_nxt    = 1'b1;
        addr_nxt  = w_row + ADDR_W'(i_cnt);
        kind_nxt  = RD_W;
        state_nxt = (i_inc < {1'b0, n_cfg}) ? XRD : DRAIN;
      end
      DRAIN: begin
        state_nxt = WRITE;
      end
      WRITE: begin
        wr_nxt    = 1'b1;
        addr_nxt  = yb_cfg + ADDR_W'(j_cnt);
        state_nxt = (j_inc < {1'b0, m_cfg}) ? BIAS : FIN;
      end
      FIN: begin
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Registered memory strobes, status flags and the read-tag pipeline
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr  <= '0;
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      kind_q    <= RD_NONE;
      kind_d    <= RD_NONE;
    end else begin
      mem_addr  <= addr_nxt;
      mem_rd_en <= rd_nxt;
      mem_wr_en <= wr_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      kind_q    <= kind_nxt;
      kind_d    <= kind_q;
    end
  end

  // Config latch, counters, accumulator, write data and arg-max tracking
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_cfg       <= '0;
      m_cfg       <= '0;
      xb_cfg      <= '0;
      bb_cfg      <= '0;
      yb_cfg      <= '0;
      relu_cfg    <= 1'b0;
      i_cnt       <= '0;
      j_cnt       <= '0;
      w_row       <= '0;
      x_q         <= '0;
      acc         <= '0;
      mem_wr_data <= '0;
      max_idx     <= '0;
      max_val     <= '0;
    end else begin
      acc <= acc_nxt;
      if (kind_d == RD_X) begin
        x_q <= $signed(mem_rd_data);
      end
      case (state)
        IDLE: begin
          if (start) begin
            n_cfg    <= num_in;
            m_cfg    <= num_out;
            xb_cfg   <= x_base;
            bb_cfg   <= b_base;
            yb_cfg   <= y_base;
            relu_cfg <= relu_en;
            w_row    <= w_base;
            j_cnt    <= '0;
            max_idx  <= '0;
            max_val  <= '0;
          end
        end
        BIAS: i_cnt <= '0;
        WRD:  i_cnt <= i_inc[CNT_W-1:0];
        WRITE: begin
          mem_wr_data <= result;
          if ((j_cnt == '0) || ($signed(result) > $signed(max_val))) begin
            max_idx <= j_cnt;
            max_val <= result;
          end
          j_cnt <= j_inc[CNT_W-1:0];
          w_row <= w_row + ADDR_W'(n_cfg);
        end
        default: ;
      endcase
    end
  end

endmodule
